sum_accumulator: RTL
====================

Name: sum_accumulator

Overview:
Downstream consumer of the 8-bit adder stage (task-based sum unit). Accepts a stream of sum results over a valid/ready handshake and accumulates COUNT samples into a wider saturating total. Emits one block result, with sample count and overflow flag, over a second valid/ready handshake. A flush input lets the stage emit a partial block early.

Parameters:
DATA_W, 8, width of each incoming sum sample
ACC_W, 16, accumulator / result width (must be > DATA_W)
COUNT, 4, samples per block (>= 1)
CNT_W, $clog2(COUNT+1), width of sample counter / out_count

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  stage can accept a sample
in_data  input  DATA_W  sample (unsigned)
flush  input  1  request early emission of partial block
out_valid  output  1  block result valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  accumulated total (saturated)
out_count  output  CNT_W  number of samples in this result
out_ovf  output  1  saturation occurred within this block
busy  output  1  high when state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. in_ready=1 the first cycle after reset deasserts.
- Reset mid-block or mid-hold discards all partial data and any pending result.
- States: IDLE (cnt=0), ACCUM (0<cnt<COUNT), HOLD (result presented).
- in_ready = (state != HOLD). Accept = in_valid & in_ready.
- On accept: acc <= sat(acc + zero-extended in_data), cnt <= cnt+1. IDLE->ACCUM on the first accept.
- Saturation: if the (ACC_W+1)-bit sum exceeds 2^ACC_W-1, acc <= all-ones and ovf <= 1. ovf is sticky for the block.
- Block complete: on accept with cnt==COUNT-1, the final sum is written to out_sum, out_count=COUNT, out_ovf=ovf|new_ovf. out_valid rises next cycle (1-cycle latency). State -> HOLD.
- COUNT==1: every accept goes directly to HOLD.
- Flush in ACCUM (cnt>0): emit the current acc/cnt/ovf and go to HOLD. Flush together with an accept includes that sample, then emits.
- Flush in IDLE with no accept is ignored. Flush in IDLE with an accept emits a 1-sample block.
- Flush in HOLD is ignored.
- HOLD: out_sum, out_count and out_ovf stay stable while out_valid=1 and out_ready=0.
- On out_valid & out_ready: out_valid <= 0, acc <= 0, cnt <= 0, ovf <= 0, state -> IDLE. in_ready returns next cycle.
- No input is accepted in the handshake cycle itself.
- out_valid never drops without a handshake (except on reset).
- busy = (state != IDLE).

Decomposition:
- Package sum_pkg: state enum {IDLE, ACCUM, HOLD}, default width constants DATA_W_DEF=8, ACC_W_DEF=16.
- One sub-module, sat_add: combinational; ACC_W acc + DATA_W operand -> ACC_W saturated result + ovf bit. Instantiated once.
- FSM and counter stay in sum_accumulator.

Test Plan:
- Default params; feed 7, 4, 11, 200 back-to-back with out_ready=1 -> out_valid one cycle after 4th accept, out_sum=222, out_count=4, out_ovf=0, in_ready low in HOLD, high next cycle.
- ACC_W=9; feed 255, 255, 255, 1 -> after 3rd sample acc=511, ovf=1; result out_sum=511, out_count=4, out_ovf=1.
- Feed 10, 20, then flush alone -> out_sum=30, out_count=2. Separately, feed 10 with flush in the same cycle as 20 -> out_sum=30, out_count=2.
- Complete block with out_ready=0 for 5 cycles -> out_valid/out_sum/out_count stable, in_ready=0, in_valid ignored. out_ready=1 -> handshake, then IDLE with acc=0.
- Feed 50, 60, assert rst asynchronously mid-cycle -> outputs zero immediately. Then feed 1, 2, 3, 4 -> out_sum=10 (no residue).
- Flush in IDLE with no data, and flush during HOLD -> no state change, no spurious out_valid.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and default widths for the sum accumulator stage.
package sum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;

endpackage : sum_pkg

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating adder: wide accumulator plus a narrow unsigned operand.
module sat_add
   import sum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] operand,
   output logic [ACC_W-1:0]  result,
   output logic              ovf
);

   logic [ACC_W:0] sum_full;

   // One extra bit catches the carry out; any carry clamps to all-ones.
   assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, operand};
   assign ovf      = sum_full[ACC_W];
   assign result   = ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];

endmodule : sat_add

// File: rtl/sum_accumulator.sv
// Accumulates COUNT saturated samples per block and presents the block total
// over a valid/ready handshake; flush emits a partial block early.
module sum_accumulator
   import sum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int COUNT  = 4,
   parameter int CNT_W  = $clog2(COUNT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf,
   output logic              busy
);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_sum_q, out_sum_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0]   add_result;
   logic               add_ovf;
   logic               accept;
   logic               last_sample;

   sat_add #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_sat_add (
      .acc     (acc_q),
      .operand (in_data),
      .result  (add_result),
      .ovf     (add_ovf)
   );

   assign accept      = in_valid && (state_q != HOLD);
   assign last_sample = (cnt_q == CNT_W'(COUNT - 1));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      if (accept) begin
         acc_d = add_result;
         cnt_d = cnt_q + CNT_W'(1);
         ovf_d = ovf_q | add_ovf;
         // A flush alongside a sample folds that sample in before emitting.
         if (last_sample || flush) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = add_result;
            out_count_d = cnt_q + CNT_W'(1);
            out_ovf_d   = ovf_q | add_ovf;
         end else begin
            state_d = ACCUM;
         end
      end else if (flush && (state_q == ACCUM)) begin
         state_d     = HOLD;
         out_valid_d = 1'b1;
         out_sum_d   = acc_q;
         out_count_d = cnt_q;
         out_ovf_d   = ovf_q;
      end else if ((state_q == HOLD) && out_valid_q && out_ready) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q != HOLD);
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = (state_q != IDLE);

endmodule : sum_accumulator
